// File: rtl/fft_frame_feeder_if.sv
// Sample stream from the frame feeder to the FFT sink.
//   fft_data  : signed Q15 sample
//   fft_valid : fft_data is valid
//   fft_last  : marks the final sample of a frame
//   fft_ready : sink accepts the current sample
// master = feeder side, slave = FFT side.
interface fft_frame_feeder_if;
  logic [15:0] fft_data;
  logic        fft_valid;
  logic        fft_last;
  logic        fft_ready;

  modport master (
    output fft_data,
    output fft_valid,
    output fft_last,
    input  fft_ready
  );

  modport slave (
    input  fft_data,
    input  fft_valid,
    input  fft_last,
    output fft_ready
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// Captures one ADC channel, decimates by DECIM, converts offset binary to
// signed Q15, buffers FFT_LEN samples and streams the frame to the FFT over
// a valid/ready handshake with a last marker.
//
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   start       : one-cycle pulse arming one frame capture (ignored while busy)
//   ad_data     : ADC sample, offset binary
//   ad_otr      : ADC over-range flag aligned with ad_data
//   fft         : sample stream to the FFT (master side)
//   busy        : high in CAPTURE, STREAM and DONE
//   frame_done  : one-cycle pulse after the last sample is accepted
//   otr_flag    : sticky over-range seen in the current frame
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for start
// CAPTURE | writing one sample every DECIM cycles into the buffer
// STREAM  | reading the buffer out to the FFT sink
// DONE    | one cycle, frame_done=1; re-arms if CONTINUOUS
module fft_frame_feeder #(
  parameter int DATA_W     = 10,
  parameter int FFT_LEN    = 256,
  parameter int DECIM      = 156,
  parameter int CONTINUOUS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              ad_otr,
  fft_frame_feeder_if.master fft,
  output logic              busy,
  output logic              frame_done,
  output logic              otr_flag
);

  localparam int AW = $clog2(FFT_LEN);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_STREAM  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] decim_cnt_q, decim_cnt_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d;
  logic [AW:0]   rd_idx_q, rd_idx_d;
  logic          otr_q, otr_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [15:0]   rd_data_q;
  logic [15:0]   buf_mem [FFT_LEN];

  logic          arm;
  logic          wr_en;
  logic          rd_en;
  logic          xfer;
  logic [15:0]   sample_q15;

  // Inverting the MSB turns offset binary into two's complement; the
  // sample is then left-justified into Q15.
  assign sample_q15 = {~ad_data[DATA_W-1], ad_data[DATA_W-2:0], {(16-DATA_W){1'b0}}};

  assign arm   = ((state_q == S_IDLE) && start) ||
                 ((state_q == S_DONE) && (CONTINUOUS != 0));
  assign wr_en = (state_q == S_CAPTURE) && (decim_cnt_q == '0);
  assign xfer  = valid_q && fft.fft_ready;
  // Prefetch the next word whenever the output register is empty or is
  // being emptied this cycle, so a continuously ready sink sees no bubble.
  assign rd_en = (state_q == S_STREAM) && (rd_idx_q != (AW+1)'(FFT_LEN)) &&
                 (!valid_q || fft.fft_ready);

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      decim_cnt_q <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      otr_q       <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      decim_cnt_q <= decim_cnt_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      otr_q       <= otr_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      // Registered read port of the frame buffer; doubles as output register.
      if (rd_en) begin
        rd_data_q <= buf_mem[rd_idx_q[AW-1:0]];
      end
    end
  end

  // Frame buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_mem[wr_idx_q] <= sample_q15;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_CAPTURE;
      S_CAPTURE: if (wr_en && (wr_idx_q == AW'(FFT_LEN-1))) state_d = S_STREAM;
      S_STREAM:  if (xfer && last_q) state_d = S_DONE;
      S_DONE:    state_d = (CONTINUOUS != 0) ? S_CAPTURE : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Counters, sticky flag and stream output control
  always_comb begin
    decim_cnt_d = decim_cnt_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    otr_d       = otr_q;
    valid_d     = valid_q;
    last_d      = last_q;

    if (arm) begin
      decim_cnt_d = '0;
      wr_idx_d    = '0;
      rd_idx_d    = '0;
      otr_d       = 1'b0;
    end else if (state_q == S_CAPTURE) begin
      decim_cnt_d = (decim_cnt_q == DW'(DECIM-1)) ? '0 : decim_cnt_q + 1'b1;
      if (wr_en) begin
        wr_idx_d = wr_idx_q + 1'b1;
        otr_d    = otr_q | ad_otr;
      end
    end

    if (rd_en) begin
      valid_d  = 1'b1;
      last_d   = (rd_idx_q == (AW+1)'(FFT_LEN-1));
      rd_idx_d = rd_idx_q + 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_DONE);
    otr_flag   = otr_q;
  end

  assign fft.fft_data  = rd_data_q;
  assign fft.fft_valid = valid_q;
  assign fft.fft_last  = last_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
module tb_fft_frame_feeder;
  localparam int DATA_W  = 10;
  localparam int FFT_LEN = 8;
  localparam int DECIM   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        start;
  logic [DATA_W-1:0] ad_data;
  logic              ad_otr;
  logic [1:0]        ready;
  logic              busy0, busy1, fd0, fd1, otr0, otr1;

  fft_frame_feeder_if if0();
  fft_frame_feeder_if if1();

  assign if0.fft_ready = ready[0];
  assign if1.fft_ready = ready[1];

  fft_frame_feeder #(.DATA_W(DATA_W), .FFT_LEN(FFT_LEN), .DECIM(DECIM), .CONTINUOUS(0)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .ad_data(ad_data), .ad_otr(ad_otr),
    .fft(if0), .busy(busy0), .frame_done(fd0), .otr_flag(otr0));

  fft_frame_feeder #(.DATA_W(DATA_W), .FFT_LEN(FFT_LEN), .DECIM(DECIM), .CONTINUOUS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .ad_data(ad_data), .ad_otr(ad_otr),
    .fft(if1), .busy(busy1), .frame_done(fd1), .otr_flag(otr1));

  always #5 clk = ~clk;

  logic [15:0] m_data [2];
  logic        m_valid [2], m_last [2], m_fd [2], m_busy_o [2], m_otr_o [2];
  assign m_data[0] = if0.fft_data;   assign m_data[1] = if1.fft_data;
  assign m_valid[0] = if0.fft_valid; assign m_valid[1] = if1.fft_valid;
  assign m_last[0] = if0.fft_last;   assign m_last[1] = if1.fft_last;
  assign m_fd[0] = fd0;              assign m_fd[1] = fd1;
  assign m_busy_o[0] = busy0;        assign m_busy_o[1] = busy1;
  assign m_otr_o[0] = otr0;          assign m_otr_o[1] = otr1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Scoreboard queues: {last, q15 sample}
  logic [16:0] q0[$];
  logic [16:0] q1[$];

  task automatic push(input int d, input logic [16:0] v);
    if (d == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [16:0] qpop(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic qflush(input int d);
    if (d == 0) q0.delete(); else q1.delete();
  endtask

  // Offset binary to Q15 as plain arithmetic: (code - midscale) scaled to 16 bits.
  function automatic logic [15:0] q15(input logic [DATA_W-1:0] a);
    int v;
    v = (int'(a) - (1 << (DATA_W-1))) * (1 << (16-DATA_W));
    return v[15:0];
  endfunction

  // ---------------- reference model (frame level) ----------------
  int cyc = 0;
  bit m_busy [2];
  bit m_otr [2];
  int cap_start [2];
  int nsamp [2];
  int frame_id [2];
  int first_valid_cyc [2];
  int end_cyc [2];          // DONE cycle, written by monitor

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 1'b0;
        m_otr[d]  = 1'b0;
        nsamp[d]  = FFT_LEN;
        qflush(d);
      end else begin
        if (!m_busy[d] && start[d]) begin
          m_busy[d] = 1'b1; cap_start[d] = cyc + 1; nsamp[d] = 0; m_otr[d] = 1'b0;
          frame_id[d]++; first_valid_cyc[d] = cyc + 1 + (FFT_LEN-1)*DECIM + 2;
        end else if (m_busy[d] && end_cyc[d] == cyc) begin
          if (d == 1) begin
            cap_start[d] = cyc + 1; nsamp[d] = 0; m_otr[d] = 1'b0;
            frame_id[d]++; first_valid_cyc[d] = cyc + 1 + (FFT_LEN-1)*DECIM + 2;
          end else begin
            m_busy[d] = 1'b0;
          end
        end
        if (m_busy[d] && nsamp[d] < FFT_LEN && cyc >= cap_start[d] &&
            ((cyc - cap_start[d]) % DECIM) == 0) begin
          push(d, {(nsamp[d] == FFT_LEN-1), q15(ad_data)});
          m_otr[d] = m_otr[d] | ad_otr;
          nsamp[d]++;
        end
      end
    end
    cyc++;
  end

  // ---------------- monitor ----------------
  bit          stall [2];
  logic [15:0] s_data [2];
  logic        s_last [2];
  bit          done_exp [2];
  int          seen_id [2];
  int          done_cnt [2];
  int          words [2];
  bit          seen_min, seen_max;
  logic [16:0] e;

  initial begin
    for (int d = 0; d < 2; d++) begin
      end_cyc[d] = -1; done_cnt[d] = 0; words[d] = 0; seen_id[d] = 0; frame_id[d] = 0;
    end
    seen_min = 1'b0; seen_max = 1'b0;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        stall[d] = 1'b0; done_exp[d] = 1'b0; end_cyc[d] = -1;
      end else begin
        if (done_exp[d] || m_fd[d]) chk("frame_done", m_fd[d], done_exp[d]);
        if (m_fd[d]) done_cnt[d]++;
        done_exp[d] = 1'b0;
        chk("busy", m_busy_o[d], m_busy[d]);
        chk("otr_flag", m_otr_o[d], m_otr[d]);
        if (stall[d]) begin
          chk("stall_valid", m_valid[d], 1);
          chk("stall_data", m_data[d], s_data[d]);
          chk("stall_last", m_last[d], s_last[d]);
        end
        if (m_valid[d] && seen_id[d] != frame_id[d]) begin
          seen_id[d] = frame_id[d];
          chk("first_valid_cycle", cyc, first_valid_cyc[d]);
        end
        if (m_valid[d] && ready[d]) begin
          chk("word_expected", qsize(d) > 0, 1);
          if (qsize(d) > 0) begin
            e = qpop(d);
            chk("fft_data", m_data[d], e[15:0]);
            chk("fft_last", m_last[d], e[16]);
            if (d == 1 && m_data[d] == e[15:0] && e[15:0] == 16'h8000) seen_min = 1'b1;
            if (d == 1 && m_data[d] == e[15:0] && e[15:0] == 16'h7FC0) seen_max = 1'b1;
          end
          words[d]++;
          if (m_last[d]) begin
            done_exp[d] = 1'b1;
            end_cyc[d]  = cyc + 1;
          end
        end
        stall[d]  = m_valid[d] && !ready[d];
        s_data[d] = m_data[d];
        s_last[d] = m_last[d];
      end
    end
  end

  // ---------------- stimulus ----------------
  int dmode;   // 0 ramp, 1 random, 2 hold, 3 endpoints/random
  int rmode;   // 0 always ready, 1 pattern 1,0,0, 2 random
  int rpat;

  task automatic tick();
    @(posedge clk);
    #1;
    case (dmode)
      0: ad_data = ad_data + 1'b1;
      1: ad_data = DATA_W'($urandom);
      3: begin
        if (cyc % 3 == 0) ad_data = '0;
        else if (cyc % 3 == 1) ad_data = '1;
        else ad_data = DATA_W'($urandom);
      end
      default: ;
    endcase
    case (rmode)
      0: ready = 2'b11;
      1: begin ready = (rpat == 0) ? 2'b11 : 2'b00; rpat = (rpat + 1) % 3; end
      default: ready = 2'($urandom);
    endcase
  endtask

  task automatic wait_done(input int d, input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt[d] < target && n < budget) begin
      tick();
      n++;
    end
    chk("frame_done_within_budget", done_cnt[d] >= target, 1);
  endtask

  task automatic pulse_start(input int d);
    tick();
    start[d] = 1'b1;
    if (dmode == 0) ad_data = '1;   // ramp reads 0 in the first capture cycle
    tick();
    start[d] = 1'b0;
  endtask

  int d0, w0, n;

  initial begin
    rst = 1'b1; start = 2'b00; ad_data = '0; ad_otr = 1'b0; ready = 2'b11;
    dmode = 0; rmode = 0; rpat = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fft_valid", if0.fft_valid, 0);
    chk("rst_fft_data", if0.fft_data, 0);
    chk("rst_fft_last", if0.fft_last, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_frame_done", fd0, 0);
    chk("rst_otr_flag", otr0, 0);
    chk("rst_busy1", busy1, 0);
    rst = 1'b0;

    // ramp, sink always ready
    dmode = 0; rmode = 0;
    d0 = done_cnt[0]; w0 = words[0];
    pulse_start(0);
    wait_done(0, d0 + 1, 300);
    repeat (4) tick();
    chk("ramp_words", words[0] - w0, FFT_LEN);
    chk("ramp_done_count", done_cnt[0] - d0, 1);

    // sink stalls 1,0,0 pattern
    dmode = 1; rmode = 1; rpat = 0;
    d0 = done_cnt[0]; w0 = words[0];
    pulse_start(0);
    wait_done(0, d0 + 1, 300);
    repeat (4) tick();
    chk("stall_words", words[0] - w0, FFT_LEN);
    chk("stall_done_count", done_cnt[0] - d0, 1);

    // midscale with one over-range on the first captured sample
    dmode = 2; rmode = 2; ad_data = 10'h200;
    d0 = done_cnt[0];
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0; ad_otr = 1'b1;
    tick();
    ad_otr = 1'b0;
    wait_done(0, d0 + 1, 300);
    repeat (3) tick();
    chk("otr_sticky_after_frame", otr0, 1);
    pulse_start(0);
    tick();
    chk("otr_cleared_on_arm", otr0, 0);
    wait_done(0, d0 + 2, 300);

    // reset during stream after three words
    dmode = 1; rmode = 0;
    repeat (3) tick();
    d0 = done_cnt[0]; w0 = words[0];
    pulse_start(0);
    n = 0;
    while (words[0] - w0 < 3 && n < 200) begin tick(); n++; end
    chk("reached_word3", (words[0] - w0) >= 3, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", if0.fft_valid, 0);
    chk("async_rst_busy", busy0, 0);
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("abort_no_frame_done", done_cnt[0] - d0, 0);
    w0 = words[0];
    pulse_start(0);
    wait_done(0, d0 + 1, 300);
    repeat (3) tick();
    chk("restart_words", words[0] - w0, FFT_LEN);

    // start pulses while busy are ignored
    dmode = 1; rmode = 2;
    d0 = done_cnt[0]; w0 = words[0];
    pulse_start(0);
    for (int i = 1; i <= 36; i++) begin
      tick();
      start[0] = (i == 5 || i == 10 || i == 33 || i == 35);
    end
    start[0] = 1'b0;
    wait_done(0, d0 + 1, 300);
    repeat (10) tick();
    chk("busy_start_words", words[0] - w0, FFT_LEN);
    chk("busy_start_done_count", done_cnt[0] - d0, 1);

    // continuous mode, three frames with endpoint codes
    dmode = 3; rmode = 2;
    d0 = done_cnt[1]; w0 = words[1];
    pulse_start(1);
    wait_done(1, d0 + 3, 900);
    chk("cont_words", words[1] - w0, 3*FFT_LEN);
    chk("cont_done_count", done_cnt[1] - d0, 3);
    chk("endpoint_8000_seen", seen_min, 1);
    chk("endpoint_7fc0_seen", seen_max, 1);

    tick();
    rst = 1'b1;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
